// File: rtl/bc_controle.sv
// Control block (BC) for the BO datapath: Moore FSM computing Resultado = (A + B) - (C + X).
// Optional build macro BC_OVF_ABORT_EN: an overflowing arithmetic step jumps straight to DONE.
module bc_controle #(
  parameter logic SEL_ADD = 1'b0,
  parameter logic SEL_SUB = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       Overflow,
  output logic       LX,
  output logic       LS,
  output logic       LH,
  output logic       SEL_ULA,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic       busy,
  output logic       done,
  output logic       ovf
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LDX    = 3'd1,
    CALC_H = 3'd2,
    CLR_S  = 3'd3,
    ADD_A  = 3'd4,
    ADD_B  = 3'd5,
    SUB_H  = 3'd6,
    DONE   = 3'd7
  } state_t;

  state_t state, state_next;
  logic   ovf_next;
  logic   arith_step;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      ovf   <= ovf_next;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next = IDLE;
    ovf_next   = ovf;
    arith_step = 1'b0;
    LX         = 1'b0;
    LS         = 1'b0;
    LH         = 1'b0;
    SEL_ULA    = SEL_ADD;
    M0         = 2'd0;
    M1         = 2'd0;
    M2         = 2'd0;
    done       = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = LDX;
          ovf_next   = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      LDX: begin
        LX         = 1'b1;
        state_next = CALC_H;
      end
      CALC_H: begin                // RH <= RX + C
        M0         = 2'd3;
        LH         = 1'b1;
        arith_step = 1'b1;
        state_next = CLR_S;
      end
      CLR_S: begin                 // RS <= RX - RX
        M1         = 2'd1;
        SEL_ULA    = SEL_SUB;
        LS         = 1'b1;
        state_next = ADD_A;
      end
      ADD_A: begin                 // RS <= RS + A
        M0         = 2'd1;
        M2         = 2'd2;
        LS         = 1'b1;
        arith_step = 1'b1;
        state_next = ADD_B;
      end
      ADD_B: begin                 // RS <= RS + B
        M0         = 2'd2;
        M2         = 2'd2;
        LS         = 1'b1;
        arith_step = 1'b1;
        state_next = SUB_H;
      end
      SUB_H: begin                 // RS <= RS - RH
        M1         = 2'd3;
        M2         = 2'd2;
        SEL_ULA    = SEL_SUB;
        LS         = 1'b1;
        arith_step = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // The step's own load still happens; only the flag (and optionally the sequence) reacts.
    if (arith_step && Overflow) begin
      ovf_next = 1'b1;
`ifdef BC_OVF_ABORT_EN
      state_next = DONE;
`else
      state_next = state_next;
`endif
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bc_controle.sv
// Self-checking bench for bc_controle: a small BO datapath model closes the loop and
// results are compared against an arithmetic reference of (A + B) - (C + X).
module tb_bc_controle;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b, c;
  logic [7:0]  x;
  logic        overflow;
  logic        lx, ls, lh, sel_ula, busy, done, ovf;
  logic [1:0]  m0, m1, m2;

  logic [15:0] rx, rs, rh, m0_out, m1_out, m2_out, alu;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bc_controle dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .Overflow (overflow),
    .LX       (lx),
    .LS       (ls),
    .LH       (lh),
    .SEL_ULA  (sel_ula),
    .M0       (m0),
    .M1       (m1),
    .M2       (m2),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  // BO datapath model: muxes, ALU with signed overflow, and the three registers.
  always_comb begin
    case (m0)
      2'd0:    m0_out = 16'd0;
      2'd1:    m0_out = a;
      2'd2:    m0_out = b;
      default: m0_out = c;
    endcase
    case (m1)
      2'd0:    m1_out = m0_out;
      2'd1:    m1_out = rx;
      2'd2:    m1_out = rs;
      default: m1_out = rh;
    endcase
    case (m2)
      2'd0:    m2_out = rx;
      2'd1:    m2_out = m0_out;
      2'd2:    m2_out = rs;
      default: m2_out = rh;
    endcase
    alu = sel_ula ? (m2_out - m1_out) : (m2_out + m1_out);
    if (sel_ula)
      overflow = (m2_out[15] != m1_out[15]) && (alu[15] != m2_out[15]);
    else
      overflow = (m2_out[15] == m1_out[15]) && (alu[15] != m2_out[15]);
  end

  always_ff @(posedge clk) begin
    if (lx) rx <= {8'd0, x};
    if (ls) rs <= alu;
    if (lh) rh <= alu;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit out_of_range(input int v);
    return (v > 32767) || (v < -32768);
  endfunction

  function automatic int wrap16(input int v);
    logic [15:0] t;
    t = v[15:0];
    return int'($signed(t));
  endfunction

  // Reference: result, overflow flag, done latency, and whether Resultado is defined.
  task automatic ref_op(input logic [15:0] ia, ib, ic, input logic [7:0] ix,
                        output logic [15:0] res, output bit ov, output int lat, output bit res_known);
    int  s_h, s_ab, s_r;
    bit  o_h, o_ab, o_r;
    s_h  = int'(ix) + int'($signed(ic));
    s_ab = int'($signed(ia)) + int'($signed(ib));
    s_r  = wrap16(s_ab) - wrap16(s_h);
    o_h  = out_of_range(s_h);
    o_ab = out_of_range(s_ab);
    o_r  = out_of_range(s_r);
    res       = s_r[15:0];
    ov        = o_h | o_ab | o_r;
    lat       = 7;
    res_known = 1'b1;
`ifdef BC_OVF_ABORT_EN
    if (o_h) begin
      lat       = 3;
      res_known = 1'b0;
    end else if (o_ab) begin
      lat = 6;
      res = s_ab[15:0];
    end
`endif
  endtask

  // One operation: start for one cycle, optional stray start pulse at cycle 'glitch'.
  task automatic run_op(input logic [15:0] ia, ib, ic, input logic [7:0] ix, input int glitch);
    logic [15:0] er;
    bit          eo, ek, seen;
    int          el, n;
    ref_op(ia, ib, ic, ix, er, eo, el, ek);
    @(posedge clk); #1;
    a = ia; b = ib; c = ic; x = ix; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n     = 1;
    seen  = 1'b0;
    while (!seen && n <= 20) begin
      start = (n == glitch);
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        check("busy_in_op", busy, 1);
        @(posedge clk); #1;
        n++;
      end
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    check("latency", n, el);
    check("busy_in_done", busy, 1);
    if (ek) check("result", rs, er);
    check("ovf", ovf, eo);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic held_start();
    logic [15:0] ta [3] = '{16'h7FFF, 16'd100, 16'h8000};
    logic [15:0] tb [3] = '{16'd1,    16'd50,  16'hFFFF};
    logic [15:0] tc [3] = '{16'd0,    16'd30,  16'd0};
    logic [7:0]  tx [3] = '{8'd0,     8'd20,   8'd0};
    logic [15:0] er;
    bit          eo, ek;
    int          el, base, n;
    @(posedge clk); #1;
    a = ta[0]; b = tb[0]; c = tc[0]; x = tx[0]; start = 1'b1;
    base = cyc;
    for (int k = 0; k < 3; k++) begin
      ref_op(ta[k], tb[k], tc[k], tx[k], er, eo, el, ek);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 30);
      check("held_done_seen", done, 1);
      check("held_done_cycle", cyc - base, el);
      if (ek) check("held_result", rs, er);
      check("held_ovf", ovf, eo);
      base = base + el + 1;
      if (k < 2) begin
        a = ta[k+1]; b = tb[k+1]; c = tc[k+1]; x = tx[k+1];
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("held_ovf_recleared", ovf, 0);
      end
    end
    start = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  initial begin
    int         nd;
    logic [7:0] ctl;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c = '0; x = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    run_op(16'd100, 16'd50, 16'd30, 8'd20, 0);
    run_op(16'h7FFF, 16'd1, 16'd0, 8'd0, 0);
    run_op(16'd1000, 16'd234, 16'h7FF0, 8'd200, 0);   // overflow in the C + X step
    run_op(16'h8000, 16'h8000, 16'd0, 8'd0, 0);       // wraps to zero
    run_op(16'd100, 16'd50, 16'd30, 8'd20, 4);        // stray start during ADD_A

    // Asynchronous reset mid-cycle with ovf set and LS active.
    @(posedge clk); #1;
    a = 16'h7FFF; b = 16'd1; c = 16'd0; x = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("ovf_before_rst", ovf, 1);
    rst = 1'b1;
    #1;
    ctl = {lx, ls, lh, sel_ula, m0, m1 | m2};
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_ovf", ovf, 0);
    check("async_rst_ctl", ctl, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_rst", busy, 0);

    // Reset while in ADD_B: no done pulse, then a clean operation.
    @(posedge clk); #1;
    a = 16'd7; b = 16'd9; c = 16'd3; x = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #4;
    rst = 1'b0;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("no_done_after_rst", nd, 0);
    run_op(16'd7, 16'd9, 16'd3, 8'd1, 0);

    held_start();

    for (int i = 0; i < 30; i++) begin
      logic [15:0] ra, rb, rc;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 16'($urandom);
      if (i % 4 == 0) rc = 16'h7FFF - 16'($urandom_range(0, 300));
      run_op(ra, rb, rc, 8'($urandom), (i % 2 == 0) ? int'($urandom_range(2, 6)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
